max7219_rx: RTL and testbench

- Receiver end of the MAX7219 serial display link; the calculator FSM drives the transmitter side (max_sck/max_cs/max_din).
- Oversamples the three lines in one system clock and deframes 16-bit words, MSB first.
- Maintains a shadow copy of the MAX7219 register file: digits 0-7, decode mode, intensity, scan limit, shutdown and display test.
- Used as an on-chip loopback monitor and as the bench-side display model for the calc top.

---
 rtl/max7219_rx.sv | 181 ++++++++++++++++++
 tb/tb_max7219_rx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_rx.sv
// MAX7219 serial link receiver with a shadow copy of the display register file.
//
// The three serial lines are asynchronous to clock, so each passes through a
// SYNC_STAGES-deep synchronizer. Words are deframed MSB first between chip-select
// edges and committed on the rising edge of cs.
//
// Ports:
//   clock, reset            system clock, synchronous active-low reset
//   max_sck, max_cs, max_din  serial link inputs (asynchronous)
//   frame_valid / frame_error one-cycle pulses for a committed / dropped frame
//   frame_addr, frame_data  address nibble and data byte of the last good frame
//   rd_digit, rd_data       digit register read port (one-cycle latency)
//   decode_mode .. display_test  shadow control registers
module max7219_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       max_sck,
    input  logic       max_cs,
    input  logic       max_din,
    output logic       frame_valid,
    output logic       frame_error,
    output logic [3:0] frame_addr,
    output logic [7:0] frame_data,
    input  logic [2:0] rd_digit,
    output logic [7:0] rd_data,
    output logic [7:0] decode_mode,
    output logic [3:0] intensity,
    output logic [2:0] scan_limit,
    output logic       shutdown_n,
    output logic       display_test
);

    typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, din_sync_q;
    logic                   cs_dly_q, sck_dly_q;
    logic                   cs_s, sck_s, din_s;
    logic                   cs_rise, cs_fall, sck_rise;

    logic [15:0] shift_q, shift_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        commit;
    logic        frame_ok, frame_bad;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        unused_shift_hi;

    logic [7:0] digit_q [8];

    // Synchronizers. Only cs and sck need the extra delay stage for edge detection;
    // din is sampled straight from its last synchronizer stage.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cs_sync_q  <= '1;
            sck_sync_q <= '0;
            din_sync_q <= '0;
            cs_dly_q   <= 1'b1;
            sck_dly_q  <= 1'b0;
        end else begin
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], max_cs};
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], max_sck};
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], max_din};
            cs_dly_q   <= cs_sync_q[SYNC_STAGES-1];
            sck_dly_q  <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign din_s    = din_sync_q[SYNC_STAGES-1];
    assign cs_rise  = cs_s & ~cs_dly_q;
    assign cs_fall  = ~cs_s & cs_dly_q;
    assign sck_rise = sck_s & ~sck_dly_q;

    // Receiver FSM and shift path.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        commit    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d   = StShift;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            StShift: begin
                // A cs rise in the same cycle as an sck rise closes the frame first.
                if (cs_rise) begin
                    state_d = StCommit;
                    commit  = 1'b1;
                end else if (sck_rise && !cs_s) begin
                    shift_d = {shift_q[14:0], din_s};
                    if (bit_cnt_q != 5'd31) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            StCommit: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // The last 16 bits shifted form the frame; earlier bits belong to downstream
    // devices in a daisy chain and the top nibble carries no address information.
    assign frame_ok        = commit && (bit_cnt_q >= 5'd16);
    assign frame_bad       = commit && (bit_cnt_q < 5'd16);
    assign wr_addr         = shift_q[11:8];
    assign wr_data         = shift_q[7:0];
    assign unused_shift_hi = ^shift_q[15:12];

    // Commit side: pulses, frame capture and register file writes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            frame_valid  <= 1'b0;
            frame_error  <= 1'b0;
            frame_addr   <= '0;
            frame_data   <= '0;
            decode_mode  <= '0;
            intensity    <= '0;
            scan_limit   <= '0;
            shutdown_n   <= 1'b0;
            display_test <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                digit_q[i] <= '0;
            end
        end else begin
            frame_valid <= frame_ok;
            frame_error <= frame_bad;
            if (frame_ok) begin
                frame_addr <= wr_addr;
                frame_data <= wr_data;
                for (int i = 0; i < 8; i++) begin
                    if (wr_addr == 4'(i + 1)) begin
                        digit_q[i] <= wr_data;
                    end
                end
                case (wr_addr)
                    4'h9:    decode_mode  <= wr_data;
                    4'hA:    intensity    <= wr_data[3:0];
                    4'hB:    scan_limit   <= wr_data[2:0];
                    4'hC:    shutdown_n   <= wr_data[0];
                    4'hF:    display_test <= wr_data[0];
                    default: ;
                endcase
            end
        end
    end

    // Read port sees the pre-write value in the cycle a digit is written.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= digit_q[rd_digit];
        end
    end

endmodule

// File: tb/tb_max7219_rx.sv
module tb_max7219_rx;

    logic       clock = 1'b0;
    logic       reset;
    logic       max_sck, max_cs, max_din;
    logic       frame_valid, frame_error;
    logic [3:0] frame_addr;
    logic [7:0] frame_data;
    logic [2:0] rd_digit;
    logic [7:0] rd_data;
    logic [7:0] decode_mode;
    logic [3:0] intensity;
    logic [2:0] scan_limit;
    logic       shutdown_n, display_test;

    always #5 clock = ~clock;

    max7219_rx #(.SYNC_STAGES(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .max_sck      (max_sck),
        .max_cs       (max_cs),
        .max_din      (max_din),
        .frame_valid  (frame_valid),
        .frame_error  (frame_error),
        .frame_addr   (frame_addr),
        .frame_data   (frame_data),
        .rd_digit     (rd_digit),
        .rd_data      (rd_data),
        .decode_mode  (decode_mode),
        .intensity    (intensity),
        .scan_limit   (scan_limit),
        .shutdown_n   (shutdown_n),
        .display_test (display_test)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int valid_seen = 0, error_seen = 0;
    int valid_exp  = 0, error_exp  = 0;

    // Reference register file.
    logic [7:0] m_digit [8];
    logic [7:0] m_decode;
    logic [3:0] m_int;
    logic [2:0] m_scan;
    logic       m_shdn, m_test;
    logic [3:0] m_addr;
    logic [7:0] m_data;

    always @(negedge clock) begin
        if (frame_valid) valid_seen++;
        if (frame_error) error_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_digit[i] = 8'h00;
        m_decode = 8'h00;
        m_int    = 4'h0;
        m_scan   = 3'h0;
        m_shdn   = 1'b0;
        m_test   = 1'b0;
        m_addr   = 4'h0;
        m_data   = 8'h00;
    endtask

    // A frame of n bits is good when n >= 16; its payload is the last 16 bits sent.
    task automatic model_frame(input logic [63:0] word, input int nbits);
        logic [15:0] w;
        if (nbits < 16) begin
            error_exp++;
            return;
        end
        valid_exp++;
        w      = word[15:0];
        m_addr = w[11:8];
        m_data = w[7:0];
        if (m_addr >= 4'd1 && m_addr <= 4'd8) m_digit[int'(m_addr) - 1] = m_data;
        else if (m_addr == 4'h9) m_decode = m_data;
        else if (m_addr == 4'hA) m_int    = m_data[3:0];
        else if (m_addr == 4'hB) m_scan   = m_data[2:0];
        else if (m_addr == 4'hC) m_shdn   = m_data[0];
        else if (m_addr == 4'hF) m_test   = m_data[0];
    endtask

    task automatic check_regs(input string tag);
        check_eq({tag, ".addr"},  32'(frame_addr),   32'(m_addr));
        check_eq({tag, ".data"},  32'(frame_data),   32'(m_data));
        check_eq({tag, ".dec"},   32'(decode_mode),  32'(m_decode));
        check_eq({tag, ".int"},   32'(intensity),    32'(m_int));
        check_eq({tag, ".scan"},  32'(scan_limit),   32'(m_scan));
        check_eq({tag, ".shdn"},  32'(shutdown_n),   32'(m_shdn));
        check_eq({tag, ".test"},  32'(display_test), 32'(m_test));
    endtask

    task automatic check_digits(input string tag);
        for (int d = 0; d < 8; d++) begin
            rd_digit = 3'(d);
            tick();
            check_eq($sformatf("%s.dig%0d", tag, d), 32'(rd_data), 32'(m_digit[d]));
        end
    endtask

    // Shift out the low nbits of word MSB first, each sck phase lasting ph clocks.
    task automatic shift_bits(input logic [63:0] word, input int nbits, input int ph,
                              input int rst_after);
        max_cs = 1'b0;
        repeat (3) tick();
        for (int i = nbits - 1; i >= 0; i--) begin
            if (rst_after > 0 && (nbits - 1 - i) == rst_after) reset = 1'b0;
            max_sck = 1'b0;
            max_din = word[i];
            repeat (ph) tick();
            max_sck = 1'b1;
            repeat (ph) tick();
        end
        max_sck = 1'b0;
        repeat (ph) tick();
    endtask

    task automatic send_frame(input string tag, input logic [63:0] word, input int nbits,
                              input int ph);
        logic [15:0] w;
        logic [7:0]  old_rd;
        int          sel;
        bit          ok;
        w   = word[15:0];
        ok  = (nbits >= 16);
        sel = (ok && w[11:8] >= 4'd1 && w[11:8] <= 4'd8) ? int'(w[11:8]) - 1
                                                        : int'($urandom_range(0, 7));
        rd_digit = 3'(sel);
        shift_bits(word, nbits, ph, 0);
        old_rd = m_digit[sel];
        model_frame(word, nbits);
        max_cs = 1'b1;
        tick();
        check_eq({tag, ".e1"}, {frame_valid, frame_error}, 2'b00);
        tick();
        check_eq({tag, ".e2"}, {frame_valid, frame_error}, 2'b00);
        tick();
        check_eq({tag, ".e3"}, {frame_valid, frame_error}, {ok, !ok});
        check_eq({tag, ".rdold"}, 32'(rd_data), 32'(old_rd));
        check_regs(tag);
        tick();
        check_eq({tag, ".e4"}, {frame_valid, frame_error}, 2'b00);
        check_eq({tag, ".rdnew"}, 32'(rd_data), 32'(m_digit[sel]));
        check_digits(tag);
    endtask

    initial begin
        int nb;
        int nb_tab [6] = '{9, 15, 16, 17, 24, 32};
        logic [63:0] word;

        reset    = 1'b0;
        max_sck  = 1'b0;
        max_cs   = 1'b1;
        max_din  = 1'b0;
        rd_digit = 3'd0;
        model_reset();

        // Reset state.
        repeat (3) tick();
        check_eq("rst.pulse", {frame_valid, frame_error}, 2'b00);
        check_regs("rst");
        reset = 1'b1;
        tick();
        check_digits("rst");

        // Digit write, then control registers.
        send_frame("dig", 64'h0355, 16, 4);
        send_frame("int",  64'h0A1F, 16, 4);
        send_frame("scan", 64'h0B07, 16, 4);
        send_frame("shdn", 64'h0C01, 16, 4);
        send_frame("test", 64'h0F01, 16, 4);
        send_frame("dec",  64'h09FF, 16, 4);
        send_frame("nop",  64'h0D12, 16, 4);

        // Short frame keeps the previous capture.
        send_frame("short", 64'h1AB, 9, 4);

        // Daisy chain: only the trailing 16 bits count.
        send_frame("daisy32", 64'h0A05_0108, 32, 4);
        send_frame("daisy17", 64'h1_0101, 17, 4);

        // Reset asserted mid-frame and held through the end of the frame.
        shift_bits(64'h0477, 16, 4, 8);
        max_cs = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        model_reset();
        tick();
        check_eq("midrst.v", 32'(valid_seen), 32'(valid_exp));
        check_eq("midrst.e", 32'(error_seen), 32'(error_exp));
        check_regs("midrst");
        check_digits("midrst");
        send_frame("clean", 64'h0477, 16, 4);

        // sck activity with cs high must be ignored.
        for (int i = 0; i < 6; i++) begin
            max_din = 1'($urandom);
            max_sck = 1'b1;
            repeat (3) tick();
            max_sck = 1'b0;
            repeat (3) tick();
        end
        check_eq("idle.v", 32'(valid_seen), 32'(valid_exp));
        check_eq("idle.e", 32'(error_seen), 32'(error_exp));
        check_regs("idle");

        // Randomized frames with random lengths and sck phase widths.
        for (int k = 0; k < 24; k++) begin
            nb   = (k % 3 == 0) ? int'($urandom_range(1, 40)) : nb_tab[$urandom_range(0, 5)];
            word = {$urandom, $urandom};
            send_frame($sformatf("rnd%0d", k), word, nb, int'($urandom_range(2, 5)));
        end

        check_eq("tot.v", 32'(valid_seen), 32'(valid_exp));
        check_eq("tot.e", 32'(error_seen), 32'(error_exp));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
